// File: rtl/xadc_scan_pwm_if.sv
// DRP-side bundle between xadc_wiz_0 and xadc_scan_pwm.
// The scanner is the DRP master; the XADC (or a bench model) is the slave.
interface xadc_scan_pwm_if;
    logic        eoc_in;
    logic        drdy_in;
    logic [15:0] do_in;
    logic        den_out;
    logic [6:0]  daddr_out;
    logic        dwe_out;

    modport master (
        input  eoc_in, drdy_in, do_in,
        output den_out, daddr_out, dwe_out
    );

    modport slave (
        output eoc_in, drdy_in, do_in,
        input  den_out, daddr_out, dwe_out
    );
endinterface

// File: rtl/xadc_scan_pwm.sv
// Multi-channel XADC DRP scanner: one read sweep per end-of-conversion,
// optional per-channel IIR filter, one glitch-free PWM output per channel.
module xadc_scan_pwm #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [6:0]  BASE_ADDR = 7'h10,
    parameter int unsigned CTR_LEN   = 8,
    parameter int unsigned AVG_SHIFT = 0,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    xadc_scan_pwm_if.master       drp,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  sample_valid,
    output logic [3:0]            sample_ch,
    output logic [11:0]           sample_data,
    output logic                  busy,
    output logic                  overrun,
    output logic                  timeout_err
);
    localparam int unsigned ACC_W = 12 + AVG_SHIFT;
    localparam int unsigned WT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STORE} state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [WT_W-1:0]    r_wait, w_wait_nxt;
    logic               w_tmo;
    logic               w_last;
    logic [11:0]        r_sample;
    logic               r_overrun, r_timeout;
    logic [ACC_W-1:0]   r_acc [NUM_CH];
    logic [ACC_W-1:0]   w_acc_cur;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CTR_LEN-1:0] r_ctr;
    logic [CTR_LEN-1:0] r_cmp [NUM_CH];
    logic [CTR_LEN-1:0] w_cmp [NUM_CH];
    logic [NUM_CH-1:0]  r_pwm;

    assign w_last = (r_idx == 4'(NUM_CH - 1));

    always_comb begin
        w_acc_cur = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (r_idx == 4'(i)) w_acc_cur = r_acc[i];
        end
    end

    // acc + s - (acc >> k) always lands back in [0, 2^ACC_W), so modular
    // arithmetic at ACC_W bits is exact; k = 0 collapses to acc = s.
    assign w_acc_nxt = w_acc_cur + ACC_W'(r_sample) - (w_acc_cur >> AVG_SHIFT);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        w_tmo       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (drp.eoc_in) begin
                    w_state_nxt = S_REQ;
                    w_idx_nxt   = '0;
                end
            end
            S_REQ: begin
                w_state_nxt = S_WAIT;
                w_wait_nxt  = '0;
            end
            S_WAIT: begin
                if (drp.drdy_in) begin
                    w_state_nxt = S_STORE;
                end else if (r_wait == WT_W'(TIMEOUT - 1)) begin
                    w_tmo = 1'b1;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_REQ;
                        w_idx_nxt   = r_idx + 4'd1;
                    end
                end else begin
                    w_wait_nxt = r_wait + WT_W'(1);
                end
            end
            S_STORE: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_REQ;
                    w_idx_nxt   = r_idx + 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_wait    <= '0;
            r_sample  <= '0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            if (r_state == S_WAIT && drp.drdy_in) r_sample <= drp.do_in[15:4];
            if (r_state == S_STORE) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    if (r_idx == 4'(i)) r_acc[i] <= w_acc_nxt;
                end
            end
            if (drp.eoc_in && r_state != S_IDLE) r_overrun <= 1'b1;
            if (w_tmo) r_timeout <= 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cmp[i] = r_acc[i][ACC_W-1 -: CTR_LEN];
        end
    end

    // Duty only changes at the all-ones count so every period is whole.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctr <= '0;
            r_pwm <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) r_cmp[i] <= '0;
        end else begin
            r_ctr <= r_ctr + CTR_LEN'(1);
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (r_ctr == '1) r_cmp[i] <= w_cmp[i];
                r_pwm[i] <= (r_ctr < r_cmp[i]);
            end
        end
    end

    assign drp.den_out   = (r_state == S_REQ);
    assign drp.daddr_out = (r_state == S_IDLE) ? '0 : BASE_ADDR + 7'(r_idx);
    assign drp.dwe_out   = 1'b0;
    assign pwm_out       = r_pwm;
    assign sample_valid  = (r_state == S_STORE);
    assign sample_ch     = (r_state == S_STORE) ? r_idx : '0;
    assign sample_data   = (r_state == S_STORE) ? w_acc_nxt[ACC_W-1 -: 12] : '0;
    assign busy          = (r_state != S_IDLE);
    assign overrun       = r_overrun;
    assign timeout_err   = r_timeout;
endmodule

// File: tb/tb_xadc_scan_pwm.sv
// Scoreboard bench for xadc_scan_pwm: a raw (AVG_SHIFT=0) and a filtered
// (AVG_SHIFT=2) instance share one DRP slave model and eoc stimulus.
module tb_xadc_scan_pwm;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xadc_scan_pwm_if bus1 ();
    xadc_scan_pwm_if bus2 ();
    assign bus2.eoc_in  = bus1.eoc_in;
    assign bus2.drdy_in = bus1.drdy_in;
    assign bus2.do_in   = bus1.do_in;

    logic [3:0]  pwm1, pwm2, ch1, ch2;
    logic [11:0] data1, data2;
    logic        sv1, sv2, busy1, busy2, ovr1, ovr2, tmo1, tmo2;

    xadc_scan_pwm #(.NUM_CH(4), .BASE_ADDR(7'h10), .CTR_LEN(8), .AVG_SHIFT(0), .TIMEOUT(64)) dut_raw (
        .clk(clk), .rst_n(rst_n), .drp(bus1.master), .pwm_out(pwm1), .sample_valid(sv1),
        .sample_ch(ch1), .sample_data(data1), .busy(busy1), .overrun(ovr1), .timeout_err(tmo1));

    xadc_scan_pwm #(.NUM_CH(4), .BASE_ADDR(7'h10), .CTR_LEN(8), .AVG_SHIFT(2), .TIMEOUT(64)) dut_iir (
        .clk(clk), .rst_n(rst_n), .drp(bus2.master), .pwm_out(pwm2), .sample_valid(sv2),
        .sample_ch(ch2), .sample_data(data2), .busy(busy2), .overrun(ovr2), .timeout_err(tmo2));

    int          total = 0;
    int          bad = 0;
    logic [15:0] q1 [$];
    logic [15:0] q2 [$];
    logic [15:0] drp_data [4];
    logic [3:0]  skip_mask = '0;
    logic [6:0]  exp_addr = 7'h10;
    int          den_cnt = 0;
    bit          chk2 = 1'b0;
    bit          mono_up = 1'b1;
    logic [11:0] prev2 [4];
    int          acc2 [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // DRP slave: answers each den 2 clocks later unless that channel is muted.
    initial begin : drp_model
        logic [6:0] a;
        bus1.drdy_in = 1'b0;
        bus1.do_in   = '0;
        forever begin
            @(negedge clk);
            if (bus1.den_out === 1'b1) begin
                a = bus1.daddr_out;
                check("den_addr", 32'(a), 32'(exp_addr));
                exp_addr = exp_addr + 7'd1;
                den_cnt++;
                if (a >= 7'h10 && a <= 7'h13 && !skip_mask[a[1:0]]) begin
                    repeat (2) @(posedge clk);
                    #1;
                    bus1.do_in   = drp_data[a[1:0]];
                    bus1.drdy_in = 1'b1;
                    @(posedge clk);
                    #1;
                    bus1.drdy_in = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (sv1 === 1'b1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL raw_unexpected: got ch=%0d data=%0h expected no sample", ch1, data1);
                end else begin
                    e = q1.pop_front();
                    check("raw_ch", 32'(ch1), 32'(e[15:12]));
                    check("raw_data", 32'(data1), 32'(e[11:0]));
                end
            end
            if (chk2 && sv2 === 1'b1) begin
                if (q2.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL iir_unexpected: got ch=%0d data=%0h expected no sample", ch2, data2);
                end else begin
                    e = q2.pop_front();
                    check("iir_ch", 32'(ch2), 32'(e[15:12]));
                    check("iir_data", 32'(data2), 32'(e[11:0]));
                    check("iir_mono", 32'(mono_up ? (data2 >= prev2[ch2[1:0]]) : (data2 <= prev2[ch2[1:0]])), 32'd1);
                    prev2[ch2[1:0]] = data2;
                end
            end
        end
    end

    task automatic sweep(input logic [15:0] d, input logic [3:0] skip, input bit extra_eoc);
        bit          done;
        logic [11:0] s;
        s = d[15:4];
        for (int c = 0; c < 4; c++) begin
            drp_data[c] = d;
            if (!skip[c]) begin
                q1.push_back({4'(c), s});
                if (chk2) begin
                    acc2[c] = acc2[c] + int'(s) - (acc2[c] >>> 2);
                    q2.push_back({4'(c), 12'(acc2[c] >>> 2)});
                end
            end
        end
        skip_mask = skip;
        exp_addr  = 7'h10;
        den_cnt   = 0;
        @(posedge clk); #1 bus1.eoc_in = 1'b1;
        @(posedge clk); #1 bus1.eoc_in = 1'b0;
        if (extra_eoc) begin
            repeat (3) @(posedge clk);
            #1 bus1.eoc_in = 1'b1;
            @(posedge clk); #1 bus1.eoc_in = 1'b0;
        end
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (busy1 === 1'b0 && busy2 === 1'b0) done = 1'b1;
        end
        check("sweep_done", 32'(done), 32'd1);
        check("den_count", 32'(den_cnt), 32'd4);
        check("raw_queue_drained", 32'(q1.size()), 32'd0);
        check("iir_queue_drained", 32'(q2.size()), 32'd0);
    endtask

    task automatic count_high(input int ch, output int n);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            if (pwm1[ch] === 1'b1) n++;
        end
    endtask

    task automatic watch_runs(input int cycles, output int n64, output int n128);
        int   run;
        logic prev;
        n64  = 0;
        n128 = 0;
        for (int i = 0; i < 300 && pwm1[0] !== 1'b0; i++) @(negedge clk);
        run  = 0;
        prev = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (pwm1[0] === 1'b1) begin
                run++;
            end else if (prev) begin
                check("pwm_run_len", 32'(run == 64 || run == 128), 32'd1);
                if (run == 64) n64++;
                if (run == 128) n128++;
                run = 0;
            end
            prev = pwm1[0];
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  n, r64, r128;
        bit  seen;
        bus1.eoc_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drp_data[c] = '0;
            prev2[c]    = '0;
            acc2[c]     = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_den", 32'(bus1.den_out), 32'd0);
        check("rst_daddr", 32'(bus1.daddr_out), 32'd0);
        check("rst_dwe", 32'(bus1.dwe_out), 32'd0);
        check("rst_pwm", 32'(pwm1), 32'd0);
        check("rst_pwm_iir", 32'(pwm2), 32'd0);
        check("rst_flags", 32'({ovr1, tmo1, sv1, ovr2, tmo2, busy2}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_release", 32'(busy1), 32'd0);

        // 1: mid-scale sweep on all four channels
        sweep(16'h8000, 4'b0000, 1'b0);
        check("t1_flags", 32'({ovr1, tmo1}), 32'd0);
        repeat (512) @(negedge clk);

        // 2: duty change lands only on period boundaries, then zero duty
        fork
            begin
                repeat (300) @(posedge clk);
                sweep(16'h4000, 4'b0000, 1'b0);
            end
            watch_runs(1024, r64, r128);
        join
        check("t2_saw_128_run", 32'(r128 >= 1), 32'd1);
        check("t2_saw_64_run", 32'(r64 >= 1), 32'd1);
        repeat (300) @(negedge clk);
        count_high(0, n);
        check("t2_duty_ch0", 32'(n), 32'd64);
        count_high(3, n);
        check("t2_duty_ch3", 32'(n), 32'd64);
        sweep(16'h0000, 4'b0000, 1'b0);
        repeat (300) @(negedge clk);
        count_high(0, n);
        check("t2_zero_duty", 32'(n), 32'd0);
        check("t2_no_timeout", 32'(tmo1), 32'd0);

        // 3: ch2 never answers
        sweep(16'hC000, 4'b0100, 1'b0);
        check("t3_timeout", 32'(tmo1), 32'd1);
        check("t3_no_overrun", 32'(ovr1), 32'd0);
        repeat (300) @(negedge clk);
        count_high(2, n);
        check("t3_ch2_kept", 32'(n), 32'd0);
        count_high(3, n);
        check("t3_ch3_read", 32'(n), 32'd192);

        // 4: eoc while busy
        sweep(16'h2000, 4'b0000, 1'b1);
        check("t4_overrun", 32'(ovr1), 32'd1);
        repeat (40) @(negedge clk);
        check("t4_no_second_sweep", 32'(den_cnt), 32'd4);
        check("t4_idle", 32'(busy1), 32'd0);
        check("t4_timeout_sticky", 32'(tmo1), 32'd1);

        // 6: asynchronous reset in the middle of WAIT
        for (int c = 0; c < 4; c++) drp_data[c] = 16'h1000;
        skip_mask = '0;
        exp_addr  = 7'h10;
        den_cnt   = 0;
        @(posedge clk); #1 bus1.eoc_in = 1'b1;
        @(posedge clk); #1 bus1.eoc_in = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus1.den_out === 1'b1) seen = 1'b1;
        end
        check("t6_den_seen", 32'(seen), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(busy1), 32'd0);
        check("t6_den", 32'(bus1.den_out), 32'd0);
        check("t6_daddr", 32'(bus1.daddr_out), 32'd0);
        check("t6_pwm", 32'(pwm1), 32'd0);
        check("t6_flags", 32'({ovr1, tmo1, sv1}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        sweep(16'h1000, 4'b0000, 1'b0);

        // 5: filtered instance converges to full scale then decays to zero
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            acc2[c]  = 0;
            prev2[c] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        chk2    = 1'b1;
        mono_up = 1'b1;
        repeat (48) sweep(16'hFFF0, 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) check("t5_full_scale", 32'(prev2[c]), 32'hFFF);
        mono_up = 1'b0;
        repeat (48) sweep(16'h0000, 4'b0000, 1'b0);
        for (int c = 0; c < 4; c++) check("t5_decay_zero", 32'(prev2[c]), 32'h0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
